// File: rtl/perceptron_seq.sv
// perceptron_seq -- sequential shift-weighted perceptron classifier.
//
// One vector of N_FEAT unsigned features is accepted per handshake.  Each
// feature is scaled by a programmable power of two (shift only), summed
// serially with saturation, and the sum is then compared against a table of
// N_CLASS targets.  The lowest-indexed matching class is reported; on a miss
// out_hit=0 and out_class is all ones.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     feature vector handshake (ready only while idle)
//   features              packed features, feature i at [i*FEAT_W +: FEAT_W]
//   cfg_we/addr/wdata     config writes, honoured only while idle:
//                         addr 0..N_FEAT-1 weights (bit2 enable, bits1:0 shift),
//                         addr N_FEAT..N_FEAT+N_CLASS-1 class targets
//   busy                  high whenever a vector is in flight
//   out_valid/out_ready   result handshake; outputs held stable until taken
//   out_class/out_hit     matched class index / match flag
//   out_sum               saturated accumulated sum
module perceptron_seq #(
  parameter int N_FEAT  = 4,
  parameter int FEAT_W  = 4,
  parameter int ACC_W   = 10,
  parameter int N_CLASS = 10,
  parameter int CLASS_W = 4,
  parameter int CFG_AW  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] features,
  input  logic                     cfg_we,
  input  logic [CFG_AW-1:0]        cfg_addr,
  input  logic [ACC_W-1:0]         cfg_wdata,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_hit,
  output logic [ACC_W-1:0]         out_sum
);

  localparam int FI_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int EXT_W = ACC_W + FEAT_W + 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    MATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturating add of one shifted feature; the sum is formed wide enough that
  // it can never wrap before being clamped to the accumulator maximum.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0]  acc,
                                               input logic [FEAT_W-1:0] feat,
                                               input logic [2:0]        wt);
    logic [EXT_W-1:0] term;
    logic [EXT_W-1:0] sum;
    term = wt[2] ? (EXT_W'(feat) << wt[1:0]) : {EXT_W{1'b0}};
    sum  = EXT_W'(acc) + term;
    if (sum > EXT_W'({ACC_W{1'b1}})) begin
      return {ACC_W{1'b1}};
    end else begin
      return sum[ACC_W-1:0];
    end
  endfunction

  state_t                     state_r, state_nx_s;
  logic [N_FEAT*FEAT_W-1:0]   feat_r;
  logic [ACC_W-1:0]           acc_r;
  logic [FI_W-1:0]            idx_r;
  logic [CLASS_W-1:0]         j_r;
  logic                       hit_r;
  logic [CLASS_W-1:0]         cls_r;
  logic [2:0]                 wt_r  [N_FEAT];
  logic [ACC_W-1:0]           tgt_r [N_CLASS];

  logic [FEAT_W-1:0]          feat_sel_s;
  logic [2:0]                 wt_sel_s;
  logic [ACC_W-1:0]           tgt_sel_s;
  logic                       hit_fin_s;
  logic [CLASS_W-1:0]         cls_fin_s;

  // Select the feature/weight addressed by idx_r and the target addressed by j_r.
  always_comb begin
    feat_sel_s = {FEAT_W{1'b0}};
    wt_sel_s   = 3'b000;
    tgt_sel_s  = {ACC_W{1'b0}};
    for (int i = 0; i < N_FEAT; i++) begin
      if (idx_r == FI_W'(i)) begin
        feat_sel_s = feat_r[i*FEAT_W +: FEAT_W];
        wt_sel_s   = wt_r[i];
      end else begin
        feat_sel_s = feat_sel_s;
      end
    end
    for (int i = 0; i < N_CLASS; i++) begin
      if (j_r == CLASS_W'(i)) begin
        tgt_sel_s = tgt_r[i];
      end else begin
        tgt_sel_s = tgt_sel_s;
      end
    end
  end

  // Fold the last table entry into the match result so it lands with DONE.
  always_comb begin
    hit_fin_s = 1'b0;
    cls_fin_s = {CLASS_W{1'b1}};
    if (hit_r) begin
      hit_fin_s = 1'b1;
      cls_fin_s = cls_r;
    end else if (acc_r == tgt_sel_s) begin
      hit_fin_s = 1'b1;
      cls_fin_s = j_r;
    end else begin
      hit_fin_s = 1'b0;
      cls_fin_s = {CLASS_W{1'b1}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx_s = ACCUM;
        else          state_nx_s = IDLE;
      end
      ACCUM: begin
        if (idx_r == FI_W'(N_FEAT - 1)) state_nx_s = MATCH;
        else                            state_nx_s = ACCUM;
      end
      MATCH: begin
        if (j_r == CLASS_W'(N_CLASS - 1)) state_nx_s = DONE;
        else                              state_nx_s = MATCH;
      end
      DONE: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Datapath: feature capture, serial accumulation and class-table scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      feat_r <= {(N_FEAT*FEAT_W){1'b0}};
      acc_r  <= {ACC_W{1'b0}};
      idx_r  <= {FI_W{1'b0}};
      j_r    <= {CLASS_W{1'b0}};
      hit_r  <= 1'b0;
      cls_r  <= {CLASS_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            feat_r <= features;
            acc_r  <= {ACC_W{1'b0}};
            idx_r  <= {FI_W{1'b0}};
          end
        end
        ACCUM: begin
          acc_r <= sat_add(acc_r, feat_sel_s, wt_sel_s);
          idx_r <= idx_r + FI_W'(1);
          j_r   <= {CLASS_W{1'b0}};
          hit_r <= 1'b0;
          cls_r <= {CLASS_W{1'b0}};
        end
        MATCH: begin
          // Only the first match is kept, so lower indices win on duplicates.
          if (!hit_r && (acc_r == tgt_sel_s)) begin
            hit_r <= 1'b1;
            cls_r <= j_r;
          end
          j_r <= j_r + CLASS_W'(1);
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Config registers; writes outside IDLE or to unmapped addresses never match.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_FEAT; i++)  wt_r[i]  <= 3'b100;
      for (int i = 0; i < N_CLASS; i++) tgt_r[i] <= {ACC_W{1'b0}};
    end else if (cfg_we && (state_r == IDLE)) begin
      for (int i = 0; i < N_FEAT; i++) begin
        if (cfg_addr == CFG_AW'(i)) wt_r[i] <= cfg_wdata[2:0];
      end
      for (int i = 0; i < N_CLASS; i++) begin
        if (cfg_addr == CFG_AW'(N_FEAT + i)) tgt_r[i] <= cfg_wdata;
      end
    end
  end

  // Registered outputs, derived from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_class <= {CLASS_W{1'b0}};
      out_hit   <= 1'b0;
      out_sum   <= {ACC_W{1'b0}};
    end else begin
      in_ready  <= (state_nx_s == IDLE);
      busy      <= (state_nx_s != IDLE);
      out_valid <= (state_nx_s == DONE);
      if ((state_r == MATCH) && (state_nx_s == DONE)) begin
        out_hit   <= hit_fin_s;
        out_class <= cls_fin_s;
        out_sum   <= acc_r;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_seq.sv
// Directed self-checking bench for perceptron_seq: a default-parameter
// instance plus a narrow-accumulator (ACC_W=6) instance for saturation.
module tb_perceptron_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, cfg_we = 1'b0, busy, out_valid, out_ready = 1'b0, out_hit;
  logic [15:0] features = 16'h0000;
  logic [4:0]  cfg_addr = 5'd0;
  logic [9:0]  cfg_wdata = 10'd0, out_sum;
  logic [3:0]  out_class;

  logic        in_valid6 = 1'b0, in_ready6, cfg_we6 = 1'b0, busy6, out_valid6, out_ready6 = 1'b0, out_hit6;
  logic [15:0] features6 = 16'h0000;
  logic [4:0]  cfg_addr6 = 5'd0;
  logic [5:0]  cfg_wdata6 = 6'd0, out_sum6;
  logic [3:0]  out_class6;

  perceptron_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .features(features),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_hit(out_hit), .out_sum(out_sum));

  perceptron_seq #(.ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .features(features6),
    .cfg_we(cfg_we6), .cfg_addr(cfg_addr6), .cfg_wdata(cfg_wdata6), .busy(busy6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_class(out_class6),
    .out_hit(out_hit6), .out_sum(out_sum6));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state for the default instance.
  logic [3:0] m_en;
  logic [7:0] m_sh;
  int         m_tg [10];
  int exp_sum, exp_cls, exp_hit;
  int exp6_sum, exp6_cls, exp6_hit;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_sum(input logic [15:0] f, input logic [3:0] en,
                                   input logic [7:0] sh, input int maxv);
    int s = 0;
    for (int i = 0; i < 4; i++)
      if (en[i]) s += int'(f[i*4 +: 4]) * (1 << sh[i*2 +: 2]);
    return (s > maxv) ? maxv : s;
  endfunction

  function automatic int model_class(input int s);
    for (int j = 0; j < 10; j++)
      if (m_tg[j] == s) return j;
    return 15;
  endfunction

  task automatic model_reset();
    m_en = 4'hF;
    m_sh = 8'h00;
    for (int j = 0; j < 10; j++) m_tg[j] = 0;
  endtask

  // Continuous check of the default instance whenever its result is valid.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      chk("model_sum", int'(out_sum), exp_sum);
      chk("model_hit", int'(out_hit), exp_hit);
      chk("model_class", int'(out_class), exp_cls);
      chk("done_in_ready", int'(in_ready), 0);
      chk("done_busy", int'(busy), 1);
    end
  end

  // Continuous check of the narrow instance.
  always @(negedge clk) begin
    if (!rst && out_valid6 === 1'b1) begin
      chk("model6_sum", int'(out_sum6), exp6_sum);
      chk("model6_hit", int'(out_hit6), exp6_hit);
      chk("model6_class", int'(out_class6), exp6_cls);
      chk("done6_in_ready", int'(in_ready6), 0);
    end
  end

  task automatic cfg_write(input int addr, input int data, input bit upd);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 5'(addr);
    cfg_wdata = 10'(data);
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (upd) begin
      if (addr < 4) begin
        m_en[addr] = data[2];
        m_sh[addr*2 +: 2] = 2'(data & 3);
      end else if (addr < 14) begin
        m_tg[addr-4] = data;
      end
    end
  endtask

  task automatic start(input logic [15:0] f);
    @(negedge clk);
    chk("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    features = f;
    exp_sum = model_sum(f, m_en, m_sh, 1023);
    exp_cls = model_class(exp_sum);
    exp_hit = (exp_cls != 15) ? 1 : 0;
    @(posedge clk);
    #1 acc_cyc = cyc;
    in_valid = 1'b0;
    features = 16'hFFFF;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("result_timeout", int'(seen), 1);
    chk("latency", cyc - acc_cyc + 1, 15);
  endtask

  task automatic ack(input int hold);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_ack_valid", int'(out_valid), 0);
    chk("post_ack_ready", int'(in_ready), 1);
    chk("post_ack_busy", int'(busy), 0);
  endtask

  initial begin
    model_reset();
    exp6_sum = 0; exp6_cls = 0; exp6_hit = 0;
    exp_sum = 0; exp_cls = 0; exp_hit = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_hit", int'(out_hit), 0);
    chk("rst_out_sum", int'(out_sum), 0);

    // Default weights x1, targets 0: features {2,3,1,4} -> 10, miss.
    start({4'd4, 4'd1, 4'd3, 4'd2});
    wait_done();
    chk("miss_sum", int'(out_sum), 10);
    chk("miss_hit", int'(out_hit), 0);
    chk("miss_class", int'(out_class), 15);
    ack(0);

    // x8,x2,x8,x2 and target[5]=38.
    cfg_write(0, 7, 1'b1);
    cfg_write(1, 5, 1'b1);
    cfg_write(2, 7, 1'b1);
    cfg_write(3, 5, 1'b1);
    cfg_write(9, 38, 1'b1);
    start({4'd4, 4'd1, 4'd3, 4'd2});
    wait_done();
    chk("hit_sum", int'(out_sum), 38);
    chk("hit_hit", int'(out_hit), 1);
    chk("hit_class", int'(out_class), 5);
    ack(2);

    // Duplicate targets at 2 and 7: lowest index wins.
    cfg_write(6, 38, 1'b1);
    cfg_write(11, 38, 1'b1);
    start({4'd4, 4'd1, 4'd3, 4'd2});
    wait_done();
    chk("dup_class", int'(out_class), 2);
    chk("dup_hit", int'(out_hit), 1);
    ack(0);

    // Weight 2 disabled; unmapped and busy writes must be dropped.
    cfg_write(2, 3, 1'b1);
    cfg_write(20, 30, 1'b0);
    start({4'd4, 4'd1, 4'd3, 4'd2});
    cfg_write(4, 30, 1'b0);
    wait_done();
    chk("dis_sum", int'(out_sum), 30);
    chk("dis_hit", int'(out_hit), 0);
    chk("dis_class", int'(out_class), 15);
    ack(0);
    start({4'd4, 4'd1, 4'd3, 4'd2});
    wait_done();
    chk("busy_wr_dropped_hit", int'(out_hit), 0);
    chk("busy_wr_dropped_sum", int'(out_sum), 30);
    ack(0);

    // Reset in the middle of accumulation.
    start({4'd4, 4'd1, 4'd3, 4'd2});
    @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_sum", int'(out_sum), 0);
    start({4'd1, 4'd1, 4'd1, 4'd1});
    wait_done();
    chk("postrst_sum", int'(out_sum), 4);
    chk("postrst_class", int'(out_class), 15);
    ack(0);

    // Narrow instance: all x8, all features 15 -> saturates at 63.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cfg_we6 = 1'b1;
      cfg_addr6 = 5'(i);
      cfg_wdata6 = 6'b000111;
      @(posedge clk);
      #1 cfg_we6 = 1'b0;
    end
    exp6_sum = model_sum(16'hFFFF, 4'hF, 8'hFF, 63);
    exp6_cls = 15;
    exp6_hit = 0;
    @(negedge clk);
    chk("sat_in_ready", int'(in_ready6), 1);
    in_valid6 = 1'b1;
    features6 = 16'hFFFF;
    @(posedge clk);
    #1 acc_cyc = cyc;
    in_valid6 = 1'b0;
    begin
      bit seen6 = 1'b0;
      for (int k = 0; k < 100 && !seen6; k++) begin
        @(negedge clk);
        if (out_valid6) seen6 = 1'b1;
      end
      chk("sat_timeout", int'(seen6), 1);
    end
    chk("sat_latency", cyc - acc_cyc + 1, 15);
    chk("sat_sum", int'(out_sum6), 63);
    // Hold off the consumer while offering a new vector that must be ignored.
    in_valid6 = 1'b1;
    features6 = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("sat_hold_valid", int'(out_valid6), 1);
      chk("sat_hold_sum", int'(out_sum6), 63);
      chk("sat_hold_in_ready", int'(in_ready6), 0);
    end
    in_valid6 = 1'b0;
    out_ready6 = 1'b1;
    @(posedge clk);
    #1 out_ready6 = 1'b0;
    @(negedge clk);
    chk("sat_post_valid", int'(out_valid6), 0);
    chk("sat_post_ready", int'(in_ready6), 1);
    @(negedge clk);
    chk("sat_still_idle", int'(busy6), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/perceptron_seq.md
# perceptron_seq

Parametrised sequential perceptron classifier: accepts one vector of N_FEAT unsigned features per handshake, accumulates them serially with per-feature power-of-two weights (shift-only, no multipliers), then scans a programmable table of N_CLASS target sums and reports the lowest-indexed class whose target equals the accumulated sum. It succeeds the fixed two-input combinational classifier. Weights and class targets are runtime-programmable through a small config port. It sits between the feature extractors and the top-level output pins.

## Interface
- N_FEAT, 4: number of feature channels
- FEAT_W, 4: width of each unsigned feature
- ACC_W, 10: accumulator / class-target width
- N_CLASS, 10: number of class-table entries; 2^CLASS_W >= N_CLASS+1 required
- CLASS_W, 4: class index width
- CFG_AW, 5: config address width; 2^CFG_AW >= N_FEAT+N_CLASS required
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  block can accept a vector (high only in IDLE)
- features  in  N_FEAT*FEAT_W  feature i = features[i*FEAT_W +: FEAT_W]
- cfg_we  in  1  config write strobe
- cfg_addr  in  CFG_AW  0..N_FEAT-1 weight regs; N_FEAT..N_FEAT+N_CLASS-1 class targets
- cfg_wdata  in  ACC_W  weight: bit2 enable, bits1:0 shift; class target: full width
- busy  out  1  high whenever state != IDLE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  CLASS_W  matched class index, all-ones on miss
- out_hit  out  1  1 if any class matched
- out_sum  out  ACC_W  accumulated sum

## Operation
- States: IDLE, ACCUM, MATCH, DONE.
- IDLE: in_ready=1. On in_valid: latch features, clear acc, feature index=0, go ACCUM.
- ACCUM: each cycle acc += enable ? (feature[idx] << shift) : 0; idx 0 first; after idx N_FEAT-1 go MATCH, class index=0.
- Accumulation saturates at 2^ACC_W-1 (no wrap).
- MATCH: each cycle compare acc to target[j]; record first j with equality (lower index wins on duplicates); always scans all N_CLASS entries; then go DONE.
- DONE: out_valid=1, outputs stable; on out_ready go IDLE.
- Miss: out_hit=0, out_class=2^CLASS_W-1, out_sum still valid.
- Config writes take effect only in IDLE; writes while busy and writes to out-of-range addresses are dropped. A write in the same IDLE cycle as an accepted vector takes effect for that vector.
- Reset values: weights = enable, shift 0 (x1); class targets = 0; state IDLE; in_ready=1, busy=0, out_valid=0, out_class=0, out_hit=0, out_sum=0.

## Timing
- Accept at cycle T (in_valid & in_ready); ACCUM cycles T+1..T+N_FEAT; MATCH cycles T+N_FEAT+1..T+N_FEAT+N_CLASS; out_valid first high at T+N_FEAT+N_CLASS+1 (cycle 15 for defaults).
- out_valid held with stable outputs until out_ready; return to IDLE the following cycle; in_ready high one cycle after the out handshake.
- Minimum spacing between accepts: N_FEAT+N_CLASS+2 cycles.
- in_valid outside IDLE ignored; features need only be stable in the accept cycle.
- rst has priority over every event; rst in any state returns to reset values next cycle, discarding the in-flight vector and all programmed config.

## Test plan
- Program weights 3'b111,3'b101,3'b111,3'b101 (x8,x2,x8,x2), target[5]=38; features {2,3,1,4} -> out_sum=38, out_hit=1, out_class=5, out_valid at T+15.
- Targets[2]=targets[7]=38, same vector -> out_class=2 (lowest index wins).
- No target equals sum (all targets 0, features nonzero) -> out_hit=0, out_class=15, out_sum correct.
- Weight 2 disabled (wdata 3'b011), features {2,3,1,4} with x8,x2,_,x2 -> out_sum=30; cfg write issued while busy -> ignored, next result unchanged.
- ACC_W=6, all weights x8, features all 15 -> out_sum=63 (saturated); out_ready low 5 cycles -> outputs stable, in_ready=0, in_valid ignored.
- rst asserted mid-ACCUM -> next cycle IDLE, in_ready=1, out_valid=0, weights x1; subsequent {1,1,1,1} -> out_sum=4.
